// File: rtl/interlock_input_conditioner_if.sv
// Board-side bundle for the interlock input conditioner: raw switches and key in,
// clean command levels, test pulse and conflict flags out.
interface interlock_input_conditioner_if;
   logic       sw_arrive;
   logic       sw_depart;
   logic       sw_fill;
   logic       sw_drain;
   logic       sw_iport;
   logic       sw_oport;
   logic       sw_select;
   logic       key_test_n;

   logic       arrive;
   logic       depart;
   logic       fill;
   logic       drain;
   logic       iport;
   logic       oport;
   logic       select;
   logic       testPressure;
   logic [1:0] conflict;

   modport master (
      output sw_arrive, sw_depart, sw_fill, sw_drain, sw_iport, sw_oport, sw_select, key_test_n,
      input  arrive, depart, fill, drain, iport, oport, select, testPressure, conflict
   );

   modport slave (
      input  sw_arrive, sw_depart, sw_fill, sw_drain, sw_iport, sw_oport, sw_select, key_test_n,
      output arrive, depart, fill, drain, iport, oport, select, testPressure, conflict
   );
endinterface

// File: rtl/interlock_input_conditioner.sv
// Synchronizes and debounces the airlock switches and test key, then registers
// conflict-free command levels and a single-cycle test pulse.
module interlock_input_conditioner #(
   parameter int DEB_CYCLES = 4,
   parameter int DEB_W      = 3
) (
   input  logic                           clock,
   input  logic                           reset,
   interlock_input_conditioner_if.slave   bus
);

   // Channel order: arrive, depart, fill, drain, iport, oport, select, key.
   localparam int               NCH      = 8;
   localparam int               KEY      = 7;
   localparam logic [NCH-1:0]   IDLE_VAL = 8'h80;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [NCH-1:0]   raw;
   logic [NCH-1:0]   s1;
   logic [NCH-1:0]   s2;
   logic [NCH-1:0]   st;
   logic [DEB_W-1:0] cnt [NCH];
   logic             prevKey;
   logic             pressEvent;

   assign raw = {bus.key_test_n, bus.sw_select, bus.sw_oport, bus.sw_iport,
                 bus.sw_drain, bus.sw_fill, bus.sw_depart, bus.sw_arrive};

   // Key idles released (1) so reset never fabricates a press edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         s1      <= IDLE_VAL;
         s2      <= IDLE_VAL;
         st      <= IDLE_VAL;
         prevKey <= 1'b1;
         for (int i = 0; i < NCH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1      <= raw;
         s2      <= s1;
         prevKey <= st[KEY];
         for (int i = 0; i < NCH; i++) begin
            if (s2[i] == st[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               st[i]  <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign pressEvent = prevKey & ~st[KEY];

   // Both members of a pair come from one st snapshot, so a simultaneous change cannot glitch.
   always_ff @(posedge clock) begin
      if (!reset) begin
         bus.arrive       <= 1'b0;
         bus.depart       <= 1'b0;
         bus.fill         <= 1'b0;
         bus.drain        <= 1'b0;
         bus.iport        <= 1'b0;
         bus.oport        <= 1'b0;
         bus.select       <= 1'b0;
         bus.testPressure <= 1'b0;
         bus.conflict     <= 2'b00;
      end else begin
         bus.arrive       <= st[0] & ~st[1];
         bus.depart       <= st[1] & ~st[0];
         bus.fill         <= st[2] & ~st[3];
         bus.drain        <= st[3] & ~st[2];
         bus.iport        <= st[4];
         bus.oport        <= st[5];
         bus.select       <= st[6];
         bus.testPressure <= pressEvent;
         bus.conflict     <= {st[2] & st[3], st[0] & st[1]};
      end
   end

endmodule

// File: tb/tb_interlock_input_conditioner.sv
// Scoreboarded bench for the interlock input conditioner: a raw-level debounce model
// predicts each output vector three edges ahead and directed checks pin latencies.
module tb_interlock_input_conditioner;

   localparam int DEB = 4;
   localparam int LOOKAHEAD = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] raw   = 8'h80;

   logic [7:0] stm;
   int         run [8];
   logic [9:0] sbq [$];

   int checks = 0;
   int errors = 0;

   interlock_input_conditioner_if bus ();

   assign bus.sw_arrive  = raw[0];
   assign bus.sw_depart  = raw[1];
   assign bus.sw_fill    = raw[2];
   assign bus.sw_drain   = raw[3];
   assign bus.sw_iport   = raw[4];
   assign bus.sw_oport   = raw[5];
   assign bus.sw_select  = raw[6];
   assign bus.key_test_n = raw[7];

   interlock_input_conditioner #(.DEB_CYCLES(DEB), .DEB_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Output vector: {testPressure, conflict[1:0], select, oport, iport, drain, fill, depart, arrive}.
   task automatic applyStimulus(input logic rstn, input logic [7:0] r);
      logic       oldKey;
      logic [9:0] e;
      reset = rstn;
      raw   = r;
      if (!rstn) begin
         stm = 8'h80;
         for (int c = 0; c < 8; c++) run[c] = 0;
         sbq.delete();
         repeat (LOOKAHEAD + 1) sbq.push_back(10'h000);
      end else begin
         oldKey = stm[7];
         for (int c = 0; c < 8; c++) begin
            if (r[c] != stm[c]) begin
               run[c] = run[c] + 1;
               if (run[c] == DEB) begin
                  stm[c] = r[c];
                  run[c] = 0;
               end
            end else begin
               run[c] = 0;
            end
         end
         e[0] = stm[0] & ~stm[1];
         e[1] = stm[1] & ~stm[0];
         e[2] = stm[2] & ~stm[3];
         e[3] = stm[3] & ~stm[2];
         e[4] = stm[4];
         e[5] = stm[5];
         e[6] = stm[6];
         e[7] = stm[0] & stm[1];
         e[8] = stm[2] & stm[3];
         e[9] = oldKey & ~stm[7];
         sbq.push_back(e);
      end
   endtask

   task automatic runCycle(input logic rstn, input logic [7:0] r,
                           output logic [9:0] expv, output logic [9:0] obsv);
      applyStimulus(rstn, r);
      @(posedge clock);
      #1;
      if (sbq.size() == 0) expv = 10'h3ff;
      else                 expv = sbq.pop_front();
      obsv = {bus.testPressure, bus.conflict, bus.select, bus.oport, bus.iport,
              bus.drain, bus.fill, bus.depart, bus.arrive};
   endtask

   task automatic doReset(input int n, input logic [7:0] r);
      logic [9:0] e, o;
      for (int i = 0; i < n; i++) runCycle(1'b0, r, e, o);
   endtask

   task automatic test_reset();
      logic [9:0] e, o;
      int pulses = 0;
      int pulseAt = -1;
      for (int i = 0; i < 3; i++) begin
         runCycle(1'b0, 8'h7f, e, o);
         checks++;
         if (o !== 10'h000) begin
            errors++;
            $display("[TB] FAIL reset_hold cycle %0d obs=%h exp=%h", i, o, 10'h000);
         end
      end
      for (int i = 0; i < 12; i++) begin
         runCycle(1'b1, 8'h7f, e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL reset_release_sb cycle %0d obs=%h exp=%h", i, o, e);
         end
         if (o[9]) begin
            pulses++;
            if (pulseAt < 0) pulseAt = i;
         end
      end
      checks++;
      if (o[6:4] !== 3'b111 || o[8:7] !== 2'b11 || o[3:0] !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_release_levels obs=%h exp=%h", o[8:0], 9'h1f0);
      end
      checks++;
      if (pulses != 1 || pulseAt != 6) begin
         errors++;
         $display("[TB] FAIL reset_key_pulse count=%0d at=%0d exp count=1 at=6", pulses, pulseAt);
      end
   endtask

   task automatic test_bounce();
      logic [9:0] e, o;
      logic [7:0] r;
      int firstRise = -1;
      doReset(2, 8'h80);
      for (int i = 0; i < 22; i++) begin
         r = 8'h80;
         r[2] = (i < 10) ? ((i % 2) == 0) : 1'b1;
         runCycle(1'b1, r, e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL bounce_sb cycle %0d obs=%h exp=%h", i, o, e);
         end
         if (o[2] && firstRise < 0) firstRise = i;
      end
      checks++;
      if (firstRise != 16) begin
         errors++;
         $display("[TB] FAIL bounce_rise_edge obs=%0d exp=%0d", firstRise, 16);
      end
   endtask

   task automatic test_glitch();
      logic [9:0] e, o;
      logic [7:0] r;
      int drainHigh = 0;
      doReset(2, 8'h80);
      for (int i = 0; i < 14; i++) begin
         r = 8'h80;
         r[3] = (i >= 1 && i <= 3);
         runCycle(1'b1, r, e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL glitch_sb cycle %0d obs=%h exp=%h", i, o, e);
         end
         if (o[3]) drainHigh++;
      end
      checks++;
      if (drainHigh != 0) begin
         errors++;
         $display("[TB] FAIL glitch_drain high_cycles=%0d exp=0", drainHigh);
      end
   endtask

   task automatic test_key();
      logic [9:0] e, o;
      logic [7:0] r;
      int pulses = 0;
      int p0 = -1;
      int p1 = -1;
      doReset(2, 8'h80);
      for (int i = 0; i < 44; i++) begin
         r = 8'h80;
         r[7] = !(i < 20 || i >= 30);
         runCycle(1'b1, r, e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL key_sb cycle %0d obs=%h exp=%h", i, o, e);
         end
         if (o[9]) begin
            pulses++;
            if (p0 < 0) p0 = i;
            else if (p1 < 0) p1 = i;
         end
      end
      checks++;
      if (pulses != 2 || p0 != 6 || p1 != 36) begin
         errors++;
         $display("[TB] FAIL key_pulses count=%0d at=%0d,%0d exp count=2 at=6,36", pulses, p0, p1);
      end
   endtask

   task automatic test_conflict();
      logic [9:0] e, o;
      logic [7:0] r;
      logic [9:0] snap [4];
      doReset(2, 8'h80);
      for (int i = 0; i < 30; i++) begin
         r = 8'h80;
         r[0] = (i < 20);
         r[1] = (i >= 10);
         r[2] = 1'b1;
         r[3] = 1'b1;
         runCycle(1'b1, r, e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL conflict_sb cycle %0d obs=%h exp=%h", i, o, e);
         end
         if (i == 15) snap[0] = o;
         if (i == 16) snap[1] = o;
         if (i == 25) snap[2] = o;
         if (i == 26) snap[3] = o;
      end
      checks++;
      if (snap[0][1:0] !== 2'b01 || snap[0][7] !== 1'b0 || snap[1][1:0] !== 2'b00 || snap[1][7] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL conflict_enter obs=%h,%h exp arrive 1->0 with conflict0 0->1", snap[0], snap[1]);
      end
      checks++;
      if (snap[2][1:0] !== 2'b00 || snap[2][7] !== 1'b1 || snap[3][1:0] !== 2'b10 || snap[3][7] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL conflict_exit obs=%h,%h exp depart 0->1 with conflict0 1->0", snap[2], snap[3]);
      end
      checks++;
      if (o[3:2] !== 2'b00 || o[8] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL conflict_filldrain obs=%h exp fill/drain 00 conflict1 1", o);
      end
   endtask

   task automatic test_reset_midcount();
      logic [9:0] e, o;
      int firstRise = -1;
      doReset(2, 8'h80);
      for (int i = 0; i < 4; i++) begin
         runCycle(1'b1, 8'ha0, e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL midcount_pre_sb cycle %0d obs=%h exp=%h", i, o, e);
         end
      end
      doReset(2, 8'ha0);
      for (int i = 0; i < 10; i++) begin
         runCycle(1'b1, 8'ha0, e, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL midcount_sb cycle %0d obs=%h exp=%h", i, o, e);
         end
         if (o[5] && firstRise < 0) firstRise = i;
      end
      checks++;
      if (firstRise != 6) begin
         errors++;
         $display("[TB] FAIL midcount_oport_edge obs=%0d exp=%0d", firstRise, 6);
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_glitch();
      test_key();
      test_conflict();
      test_reset_midcount();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
